cordic_fp_pack: RTL and testbench

Output-side converter placed directly downstream of `cordic_top`. It captures one signed Q15 sine/cosine pair, together with the 3-bit `flip_out` tag, when a single-cycle valid pulse arrives. It converts both values to IEEE754 single precision using a shared sequential normaliser that shifts one bit per cycle. It then presents the two 32-bit words with a one-cycle `valid_out` pulse. The conversion is exact, with no rounding, because every Q15 value is representable in binary32.

---
 rtl/cordic_fp_pack.sv | 137 +++++++++++++
 tb/tb_cordic_fp_pack.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_fp_pack.sv
// cordic_fp_pack
// Converts one signed Q15 sine/cosine pair from the CORDIC stage into two
// IEEE754 binary32 words. A shared one-bit-per-cycle normaliser shifts both
// magnitudes left until bit 15 is set, so the result is exact.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   valid_in   single-cycle strobe qualifying sin_q15/cos_q15/flip_in
//   sin_q15    signed Q15 sine
//   cos_q15    signed Q15 cosine
//   flip_in    opaque 3-bit tag, carried through unchanged
//   sin_fp     binary32 sine
//   cos_fp     binary32 cosine
//   flip_out   tag captured with the pair
//   valid_out  one-cycle pulse when sin_fp/cos_fp/flip_out are new
//   busy       high while a conversion is in flight; valid_in ignored then
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for valid_in
// NORM  | shifting un-normalised channels one bit per cycle
// DONE  | outputs packed, valid_out high for this single cycle
module cordic_fp_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] sin_q15,
    input  logic [15:0] cos_q15,
    input  logic [2:0]  flip_in,
    output logic [31:0] sin_fp,
    output logic [31:0] cos_fp,
    output logic [2:0]  flip_out,
    output logic        valid_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        sign_s;
    logic        sign_c;
    logic [15:0] m_s;
    logic [15:0] m_c;
    logic [3:0]  n_s;
    logic [3:0]  n_c;
    logic [2:0]  flip_q;
    logic        done_s;
    logic        done_c;

    // Two's-complement magnitude; -32768 yields 0x8000, which is already
    // normalised and needs no special case.
    function automatic logic [15:0] abs16(input logic [15:0] x);
        return x[15] ? (~x + 16'd1) : x;
    endfunction

    // m is normalised (bit 15 set) unless it is zero. Bit 15 is the implied
    // leading one, so only m[14:0] reaches the mantissa.
    function automatic logic [31:0] pack(input logic       sgn,
                                         input logic [15:0] m,
                                         input logic [3:0]  n);
        logic [7:0] exponent;
        exponent = 8'd127 - {4'd0, n};
        if (m == 16'd0) begin
            return 32'd0;
        end
        return {sgn, exponent, m[14:0], 8'd0};
    endfunction

    assign done_s = m_s[15] || (m_s == 16'd0);
    assign done_c = m_c[15] || (m_c == 16'd0);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign_s    <= 1'b0;
            sign_c    <= 1'b0;
            m_s       <= 16'd0;
            m_c       <= 16'd0;
            n_s       <= 4'd0;
            n_c       <= 4'd0;
            flip_q    <= 3'd0;
            sin_fp    <= 32'd0;
            cos_fp    <= 32'd0;
            flip_out  <= 3'd0;
            valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        sign_s <= sin_q15[15];
                        sign_c <= cos_q15[15];
                        m_s    <= abs16(sin_q15);
                        m_c    <= abs16(cos_q15);
                        n_s    <= 4'd0;
                        n_c    <= 4'd0;
                        flip_q <= flip_in;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (done_s && done_c) begin
                        sin_fp    <= pack(sign_s, m_s, n_s);
                        cos_fp    <= pack(sign_c, m_c, n_c);
                        flip_out  <= flip_q;
                        valid_out <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (!done_s) begin
                            m_s <= {m_s[14:0], 1'b0};
                            n_s <= n_s + 4'd1;
                        end
                        if (!done_c) begin
                            m_c <= {m_c[14:0], 1'b0};
                            n_c <= n_c + 4'd1;
                        end
                    end
                end
                DONE: begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    valid_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_fp_pack.sv
// tb_cordic_fp_pack
// Directed bench for cordic_fp_pack. A cycle-level behavioural model
// predicts every output each cycle from plain integer arithmetic; a single
// compare process checks the DUT on the falling edge. Directed scenarios
// add literal expectations for values, latency and busy length.
module tb_cordic_fp_pack;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] sin_q15;
    logic [15:0] cos_q15;
    logic [2:0]  flip_in;
    logic [31:0] sin_fp;
    logic [31:0] cos_fp;
    logic [2:0]  flip_out;
    logic        valid_out;
    logic        busy;

    int total;
    int bad;
    int vcount;

    cordic_fp_pack dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .sin_q15   (sin_q15),
        .cos_q15   (cos_q15),
        .flip_in   (flip_in),
        .sin_fp    (sin_fp),
        .cos_fp    (cos_fp),
        .flip_out  (flip_out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position of the highest set bit of |x| (x nonzero).
    function automatic int msb_pos(input logic [15:0] x);
        int v;
        int mag;
        int e;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        e   = 0;
        while ((1 << (e + 1)) <= mag) e++;
        return e;
    endfunction

    // value = x / 2^15; for |x| in [2^e, 2^(e+1)) the binary32 exponent is
    // e - 15 and the fraction is the bits below the leading one.
    function automatic logic [31:0] fp_model(input logic [15:0] x);
        int v;
        int mag;
        int e;
        logic [31:0] r;
        v = int'($signed(x));
        if (v == 0) return 32'd0;
        mag = (v < 0) ? -v : v;
        e   = msb_pos(x);
        r        = 32'd0;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + e - 15);
        r[22:0]  = 23'((mag - (1 << e)) << (23 - e));
        return r;
    endfunction

    function automatic int shifts_model(input logic [15:0] x);
        if (x == 16'd0) return 0;
        return 15 - msb_pos(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          started;
    bit          m_active;
    int          m_t;
    logic [31:0] m_sin, m_cos, p_sin, p_cos;
    logic [2:0]  m_flip, p_flip;
    logic        m_valid;

    initial begin
        started  = 0;
        m_active = 0;
        m_t      = 0;
        m_sin    = 0;
        m_cos    = 0;
        m_flip   = 0;
        m_valid  = 0;
        p_sin    = 0;
        p_cos    = 0;
        p_flip   = 0;
    end

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_active = 0;
            m_t      = 0;
            m_sin    = 0;
            m_cos    = 0;
            m_flip   = 0;
            m_valid  = 0;
        end else if (m_active) begin
            if (m_t == 0) begin
                m_active = 0;
                m_valid  = 0;
            end else begin
                m_t--;
                if (m_t == 0) begin
                    m_sin   = p_sin;
                    m_cos   = p_cos;
                    m_flip  = p_flip;
                    m_valid = 1;
                end
            end
        end else if (valid_in) begin
            int ns, nc;
            ns       = shifts_model(sin_q15);
            nc       = shifts_model(cos_q15);
            m_active = 1;
            m_t      = ((ns > nc) ? ns : nc) + 1;
            p_sin    = fp_model(sin_q15);
            p_cos    = fp_model(cos_q15);
            p_flip   = flip_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_valid_out", {31'd0, valid_out}, {31'd0, m_valid});
            chk("cyc_busy",      {31'd0, busy},      {31'd0, m_active});
            chk("cyc_sin_fp",    sin_fp,             m_sin);
            chk("cyc_cos_fp",    cos_fp,             m_cos);
            chk("cyc_flip_out",  {29'd0, flip_out},  {29'd0, m_flip});
            if (valid_out === 1'b1) vcount++;
        end
    end

    // ---------------- directed stimulus ----------------
    // Called at posedge+1 with busy low; pulses valid_in for one cycle.
    task automatic run_pair(input logic [15:0] s, input logic [15:0] c,
                            input logic [2:0] f, input logic [31:0] es,
                            input logic [31:0] ec, input int elat);
        int lat;
        int bc;
        bit seen;
        valid_in = 1'b1;
        sin_q15  = s;
        cos_q15  = c;
        flip_in  = f;
        @(posedge clk); #1;
        valid_in = 1'b0;
        bc   = busy ? 1 : 0;
        seen = 0;
        lat  = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (busy) bc++;
            if (valid_out) begin
                seen = 1;
                lat  = i;
            end
        end
        chk("valid_seen",  {31'd0, seen}, 32'd1);
        chk("latency",     lat, elat);
        chk("sin_fp",      sin_fp, es);
        chk("cos_fp",      cos_fp, ec);
        chk("flip_out",    {29'd0, flip_out}, {29'd0, f});
        chk("busy_cycles", bc, elat + 1);
        @(posedge clk); #1;
        chk("pulse_width", {31'd0, valid_out}, 32'd0);
        chk("busy_low",    {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int v0;
        bit seen;
        total    = 0;
        bad      = 0;
        vcount   = 0;
        rst      = 1'b1;
        valid_in = 1'b0;
        sin_q15  = 16'd0;
        cos_q15  = 16'd0;
        flip_in  = 3'd0;

        // Pin the model itself against hand-computed words.
        chk("model_7fff", fp_model(16'h7FFF), 32'h3F7FFE00);
        chk("model_0001", fp_model(16'h0001), 32'h38000000);
        chk("model_8000", fp_model(16'h8000), 32'hBF800000);
        chk("model_zero", fp_model(16'h0000), 32'h00000000);
        chk("model_e000", fp_model(16'hE000), 32'hBE800000);
        chk("model_n",    shifts_model(16'h0001), 32'd15);

        // Reset, then idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_sin",   sin_fp, 32'd0);
        chk("rst_cos",   cos_fp, 32'd0);
        chk("rst_flip",  {29'd0, flip_out}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        v0 = vcount;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_valid", vcount - v0, 32'd0);

        // Directed conversions; consecutive calls also exercise acceptance
        // in the first busy-low cycle.
        run_pair(16'h4000, 16'h8000, 3'b101, 32'h3F000000, 32'hBF800000, 2);
        run_pair(16'h7FFF, 16'h0001, 3'b010, 32'h3F7FFE00, 32'h38000000, 16);
        run_pair(16'h0000, 16'hC000, 3'b001, 32'h00000000, 32'hBF000000, 2);
        run_pair(16'h8000, 16'h8000, 3'b111, 32'hBF800000, 32'hBF800000, 1);
        run_pair(16'h8001, 16'h2000, 3'b011, 32'hBF7FFE00, 32'h3E800000, 3);
        run_pair(16'h0000, 16'h0000, 3'b100, 32'h00000000, 32'h00000000, 1);

        // Back-to-back: second pulse while busy must be dropped.
        repeat (2) @(posedge clk);
        #1;
        v0 = vcount;
        valid_in = 1'b1;
        sin_q15  = 16'h0001;
        cos_q15  = 16'h0001;
        flip_in  = 3'b011;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        valid_in = 1'b1;
        sin_q15  = 16'h4000;
        cos_q15  = 16'h4000;
        flip_in  = 3'b110;
        @(posedge clk); #1;
        valid_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 25 && !seen; i++) begin
            @(posedge clk); #1;
            if (valid_out) seen = 1;
        end
        chk("b2b_seen", {31'd0, seen}, 32'd1);
        chk("b2b_sin",  sin_fp, 32'h38000000);
        chk("b2b_flip", {29'd0, flip_out}, 32'd3);
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_pulses", vcount - v0, 32'd1);

        // Reset in the middle of normalisation drops the conversion.
        v0 = vcount;
        valid_in = 1'b1;
        sin_q15  = 16'h0001;
        cos_q15  = 16'h0001;
        flip_in  = 3'b111;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_valid", vcount - v0, 32'd0);
        chk("midrst_sin", sin_fp, 32'd0);
        chk("midrst_cos", cos_fp, 32'd0);
        run_pair(16'hE000, 16'hE000, 3'b010, 32'hBE800000, 32'hBE800000, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
